// File: rtl/testdrive_apb_pkg.sv
// Shared APB definitions: FSM states, bus widths and the byte-lane write merge.
package testdrive_apb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_state_t;

    localparam int APB_DATA_W  = 32;
    localparam int APB_STRB_W  = APB_DATA_W / 8;
    localparam int ERR_COUNT_W = 16;
    localparam int WAIT_CNT_W  = 4;

    // Lane b of the result comes from new_val when strb[b] is set, else from old_val.
    function automatic logic [APB_DATA_W-1:0] merge_bytes(
        input logic [APB_DATA_W-1:0] old_val,
        input logic [APB_DATA_W-1:0] new_val,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < APB_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/testdrive_apb_slave_ctrl.sv
// Reusable APB slave handshake: SETUP/ACCESS sequencing, wait-state counter,
// registered PREADY plus latch / response-load / commit strobes for the datapath.
module testdrive_apb_slave_ctrl
    import testdrive_apb_pkg::*;
#(
    parameter int C_WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic psel,
    input  logic penable,
    output logic latch,
    output logic resp_load,
    output logic commit,
    output logic pready
);

    apb_state_t            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    // SETUP seen in IDLE; PSEL with PENABLE already high is a protocol violation and ignored.
    assign latch  = (state == ST_IDLE) && psel && !penable;
    assign commit = (state == ST_ACCESS) && psel && pready;

    // High at exactly the edge that raises PREADY, so the datapath loads PRDATA/PSLVERR with it.
    assign resp_load = (latch && (C_WAIT_CYCLES == 0)) ||
                       ((state == ST_ACCESS) && psel && !pready && (wait_cnt == WAIT_CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            pready   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (latch) begin
                        wait_cnt <= WAIT_CNT_W'(C_WAIT_CYCLES);
                        pready   <= (C_WAIT_CYCLES == 0);
                        state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        pready <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (pready) begin
                        pready <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                        pready   <= (wait_cnt == WAIT_CNT_W'(1));
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/testdrive_apb_reg_bank.sv
// APB slave register bank: C_REG_COUNT word registers with byte-strobed writes,
// out-of-range error responses, per-register write pulses and a saturating error count.
module testdrive_apb_reg_bank
    import testdrive_apb_pkg::*;
#(
    parameter int          C_ADDR_BITS   = 10,
    parameter int          C_REG_COUNT   = 16,
    parameter int          C_WAIT_CYCLES = 0,
    parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              PSEL,
    input  logic                              PENABLE,
    input  logic                              PWRITE,
    input  logic [C_ADDR_BITS-1:0]            PADDR,
    input  logic [APB_DATA_W-1:0]             PWDATA,
    input  logic [APB_STRB_W-1:0]             PSTRB,
    output logic [APB_DATA_W-1:0]             PRDATA,
    output logic                              PREADY,
    output logic                              PSLVERR,
    output logic [APB_DATA_W*C_REG_COUNT-1:0] REG_OUT,
    output logic [C_REG_COUNT-1:0]            REG_WR,
    output logic [ERR_COUNT_W-1:0]            ERR_COUNT
);

    localparam int IDX_W = C_ADDR_BITS - 2;

    logic                   latch;
    logic                   resp_load;
    logic                   commit;

    logic [IDX_W-1:0]       idx_q;
    logic                   write_q;
    logic [APB_DATA_W-1:0]  wdata_q;
    logic [APB_STRB_W-1:0]  strb_q;

    logic [IDX_W-1:0]       req_idx;
    logic                   req_write;
    logic                   req_in_range;
    logic [APB_DATA_W-1:0]  rd_word;

    logic [APB_DATA_W-1:0]  regs [C_REG_COUNT];
    logic [ERR_COUNT_W-1:0] err_count;
    logic                   unused_addr_lsbs;

    assign unused_addr_lsbs = ^PADDR[1:0];

    testdrive_apb_slave_ctrl #(
        .C_WAIT_CYCLES(C_WAIT_CYCLES)
    ) u_ctrl (
        .clk      (CLK),
        .rst      (RST),
        .psel     (PSEL),
        .penable  (PENABLE),
        .latch    (latch),
        .resp_load(resp_load),
        .commit   (commit),
        .pready   (PREADY)
    );

    // With zero wait states the response is loaded on the SETUP edge itself,
    // before the latched copy exists, so decode from the live bus in that case.
    assign req_idx      = latch ? PADDR[C_ADDR_BITS-1:2] : idx_q;
    assign req_write    = latch ? PWRITE : write_q;
    assign req_in_range = ({{(32-IDX_W){1'b0}}, req_idx} < 32'(C_REG_COUNT));

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < C_REG_COUNT; i++) begin
            if (req_idx == IDX_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (latch) begin
            idx_q   <= PADDR[C_ADDR_BITS-1:2];
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    // PREADY is high only in the cycle after resp_load, so the response is zero at every other time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else if (resp_load) begin
            PSLVERR <= !req_in_range;
            PRDATA  <= (req_in_range && !req_write) ? rd_word : '0;
        end else begin
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < C_REG_COUNT; i++) begin
                regs[i] <= C_RESET_VALUE;
            end
        end else if (commit && write_q && req_in_range) begin
            for (int i = 0; i < C_REG_COUNT; i++) begin
                if (req_idx == IDX_W'(i)) begin
                    regs[i] <= merge_bytes(regs[i], wdata_q, strb_q);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            REG_WR <= '0;
        end else begin
            for (int i = 0; i < C_REG_COUNT; i++) begin
                REG_WR[i] <= commit && write_q && req_in_range && (req_idx == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_count <= '0;
        end else if (commit && PSLVERR && (err_count != '1)) begin
            err_count <= err_count + ERR_COUNT_W'(1);
        end
    end

    assign ERR_COUNT = err_count;

    genvar g;
    generate
        for (g = 0; g < C_REG_COUNT; g++) begin : g_reg_out
            assign REG_OUT[APB_DATA_W*g +: APB_DATA_W] = regs[g];
        end
    endgenerate

endmodule

// File: tb/tb_testdrive_apb_reg_bank.sv
// Bench for testdrive_apb_reg_bank: two instances (0 and 3 wait states) driven by an
// APB master, checked every cycle against a transfer-level model of the register bank.
module tb_testdrive_apb_reg_bank;

    localparam int NREG = 16;
    localparam int AW   = 10;
    localparam int W0   = 0;
    localparam int W1   = 3;

    logic clk = 1'b0;
    logic rst;
    logic psel [2];
    logic penable;
    logic pwrite;
    logic [AW-1:0] paddr;
    logic [31:0] pwdata;
    logic [3:0] pstrb;

    logic [31:0]        prdata  [2];
    logic               pready  [2];
    logic               pslverr [2];
    logic [32*NREG-1:0] reg_out [2];
    logic [NREG-1:0]    reg_wr  [2];
    logic [15:0]        err_cnt [2];

    // Model state
    logic [31:0]     m_reg [2][NREG];
    int              m_err [2];
    int              exp_ready_cyc [2];
    logic [31:0]     exp_rdata [2];
    logic            exp_err [2];
    int              exp_wr_cyc [2];
    logic [NREG-1:0] exp_wr_mask [2];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int last_s;
    int last_ready_cyc [2];
    int wr_seen_cyc [2][NREG];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    testdrive_apb_reg_bank #(
        .C_ADDR_BITS(AW), .C_REG_COUNT(NREG), .C_WAIT_CYCLES(W0), .C_RESET_VALUE(32'h0)
    ) u_dut0 (
        .CLK(clk), .RST(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]),
        .PREADY(pready[0]), .PSLVERR(pslverr[0]), .REG_OUT(reg_out[0]),
        .REG_WR(reg_wr[0]), .ERR_COUNT(err_cnt[0])
    );

    testdrive_apb_reg_bank #(
        .C_ADDR_BITS(AW), .C_REG_COUNT(NREG), .C_WAIT_CYCLES(W1), .C_RESET_VALUE(32'h0)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]),
        .PREADY(pready[1]), .PSLVERR(pslverr[1]), .REG_OUT(reg_out[1]),
        .REG_WR(reg_wr[1]), .ERR_COUNT(err_cnt[1])
    );

    function automatic int wait_of(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < NREG; r++) m_reg[i][r] = 32'h0;
            m_err[i]         = 0;
            exp_ready_cyc[i] = -1;
            exp_wr_cyc[i]    = -1;
            exp_wr_mask[i]   = '0;
            exp_rdata[i]     = 32'h0;
            exp_err[i]       = 1'b0;
        end
    endtask

    // Called just after a posedge; returns just after the completion edge.
    task automatic xfer(input int i, input bit wr, input logic [AW-1:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        int s;
        int idx;
        psel[i] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        @(posedge clk); #1;
        s      = cyc;
        last_s = s;
        idx    = int'(addr[AW-1:2]);
        exp_ready_cyc[i] = s + wait_of(i);
        exp_err[i]       = (idx >= NREG);
        exp_rdata[i]     = (idx < NREG && !wr) ? m_reg[i][idx] : 32'h0;
        penable = 1'b1;
        repeat (wait_of(i) + 1) @(posedge clk);
        #1;
        if (idx >= NREG) begin
            if (m_err[i] < 65535) m_err[i]++;
        end else if (wr) begin
            m_reg[i][idx]  = lane_merge(m_reg[i][idx], data, strb);
            exp_wr_cyc[i]  = cyc;
            exp_wr_mask[i] = NREG'(1) << idx;
        end
        psel[i] = 1'b0;
        penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic            er;
                logic [NREG-1:0] ew;
                er = (cyc == exp_ready_cyc[i]);
                check($sformatf("pready%0d", i), 64'(pready[i]), 64'(er));
                if (pready[i]) last_ready_cyc[i] = cyc;
                if (er) begin
                    check($sformatf("prdata%0d", i), 64'(prdata[i]), 64'(exp_rdata[i]));
                    check($sformatf("pslverr%0d", i), 64'(pslverr[i]), 64'(exp_err[i]));
                end
                ew = (cyc == exp_wr_cyc[i]) ? exp_wr_mask[i] : '0;
                check($sformatf("reg_wr%0d", i), 64'(reg_wr[i]), 64'(ew));
                for (int r = 0; r < NREG; r++) begin
                    if (reg_wr[i][r]) wr_seen_cyc[i][r] = cyc;
                    check($sformatf("reg_out%0d_r%0d", i, r), 64'(reg_out[i][32*r +: 32]),
                          64'(m_reg[i][r]));
                end
                check($sformatf("err_count%0d", i), 64'(err_cnt[i]), 64'(m_err[i]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        rst     = 1'b1;
        psel[0] = 1'b0;
        psel[1] = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        for (int i = 0; i < 2; i++) begin
            last_ready_cyc[i] = -1;
            for (int r = 0; r < NREG; r++) wr_seen_cyc[i][r] = -1;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_pready", 64'(pready[0]), 64'd0);
        check("rst_errcnt", 64'(err_cnt[1]), 64'd0);

        // Zero-wait write then read of reg2
        xfer(0, 1'b1, 10'h008, 32'h12345678, 4'hF);
        wc = cyc;
        check("w0_ready_in_access1", 64'(last_ready_cyc[0] - last_s), 64'd0);
        check("w0_reg2", 64'(reg_out[0][95:64]), 64'h12345678);
        xfer(0, 1'b0, 10'h008, 32'h0, 4'h0);
        check("w0_model_rdata", 64'(exp_rdata[0]), 64'h12345678);
        check("w0_regwr_cycle", 64'(wr_seen_cyc[0][2]), 64'(wc));

        // Three wait states: PREADY only in ACCESS cycle 4
        xfer(1, 1'b0, 10'h000, 32'h0, 4'h0);
        check("w3_ready_in_access4", 64'(last_ready_cyc[1] - last_s), 64'd3);

        // Byte-strobed merge
        xfer(0, 1'b1, 10'h004, 32'hAABBCCDD, 4'hF);
        xfer(0, 1'b1, 10'h005, 32'h11223344, 4'b0101);
        check("strb_reg1", 64'(reg_out[0][63:32]), 64'hAA22CC44);
        check("strb_model_reg1", 64'(m_reg[0][1]), 64'hAA22CC44);
        xfer(0, 1'b1, 10'h004, 32'hFFFFFFFF, 4'h0);
        check("strb0_reg1", 64'(reg_out[0][63:32]), 64'hAA22CC44);

        // Out-of-range write, then saturation of the error counter
        xfer(0, 1'b1, 10'h040, 32'hDEADBEEF, 4'hF);
        check("oor_errcnt", 64'(err_cnt[0]), 64'd1);
        force u_dut0.err_count = 16'hFFFD;
        m_err[0] = 65533;
        #1;
        release u_dut0.err_count;
        for (int k = 0; k < 4; k++) begin
            xfer(0, (k % 2) == 0, 10'h3FC, 32'h0, 4'hF);
            if (k < 3) idle(1);
        end
        check("errcnt_saturated", 64'(err_cnt[0]), 64'hFFFF);
        idle(1);

        // Abort in the second ACCESS cycle: no write, slave back in IDLE
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 10'h014; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        exp_ready_cyc[1] = cyc + W1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0;
        exp_ready_cyc[1] = -1;
        @(posedge clk); #1;
        penable = 1'b0;
        idle(1);
        xfer(1, 1'b0, 10'h014, 32'h0, 4'h0);
        check("abort_reg5", 64'(reg_out[1][191:160]), 64'h0);

        // Back-to-back writes to reg0 and reg1
        xfer(1, 1'b1, 10'h000, 32'h01020304, 4'hF);
        xfer(1, 1'b1, 10'h004, 32'h05060708, 4'hF);
        idle(2);
        check("b2b_regwr_spacing", 64'(wr_seen_cyc[1][1] - wr_seen_cyc[1][0]), 64'(W1 + 2));
        check("b2b_reg1", 64'(reg_out[1][63:32]), 64'h05060708);

        // Randomized traffic on both instances
        for (int n = 0; n < 300; n++) begin
            int   i;
            int   idx;
            logic [AW-1:0] a;
            i   = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 19));
            a   = {idx[AW-3:0], 2'($urandom_range(0, 3))};
            xfer(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(0, 2)));
        end

        // Reset during a wait state
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 10'h008; pwdata = 32'h55AA55AA; pstrb = 4'hF;
        @(posedge clk); #1;
        exp_ready_cyc[1] = cyc + W1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        psel[1] = 1'b0;
        penable = 1'b0;
        model_reset();
        check("rst_mid_pready", 64'(pready[1]), 64'd0);
        check("rst_mid_reg2", 64'(reg_out[1][95:64]), 64'h0);
        idle(2);

        for (int n = 0; n < 60; n++) begin
            int idx;
            idx = int'($urandom_range(0, 17));
            xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {idx[AW-3:0], 2'b00}, $urandom, 4'($urandom_range(0, 15)));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
